// File: rtl/ram_operand_fetch.sv
// Operand fetch controller for the dual-read-port data RAM: issues both reads, captures the
// one-cycle-latency data (with same-address write forwarding), and registers write-backs onto the RAM.
module ram_operand_fetch #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iRequest,
  input  logic [ADDR_WIDTH-1:0] iSrcAddr0,
  input  logic [ADDR_WIDTH-1:0] iSrcAddr1,
  output logic                  oReady,
  output logic                  oOperandsValid,
  output logic [DATA_WIDTH-1:0] oOperand0,
  output logic [DATA_WIDTH-1:0] oOperand1,
  input  logic                  iAccept,
  input  logic                  iWbValid,
  input  logic [ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0] iWbData,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_WIDTH-1:0] oRamWriteData,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress0,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamDataOut0,
  input  logic [DATA_WIDTH-1:0] iRamDataOut1
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    VALID
  } state_t;

  state_t                  state;
  logic                    fwd0;
  logic                    fwd1;
  logic [DATA_WIDTH-1:0]   fwd_data;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= IDLE;
      oReady           <= 1'b1;
      oOperandsValid   <= 1'b0;
      oOperand0        <= '0;
      oOperand1        <= '0;
      oRamWriteEnable  <= 1'b0;
      oRamWriteAddress <= '0;
      oRamWriteData    <= '0;
      oRamReadAddress0 <= '0;
      oRamReadAddress1 <= '0;
      fwd0             <= 1'b0;
      fwd1             <= 1'b0;
      fwd_data         <= '0;
    end else begin
      oRamWriteEnable <= iWbValid;
      if (iWbValid) begin
        oRamWriteAddress <= iWbAddr;
        oRamWriteData    <= iWbData;
      end

      case (state)
        IDLE: begin
          if (iRequest) begin
            oRamReadAddress0 <= iSrcAddr0;
            oRamReadAddress1 <= iSrcAddr1;
            oReady           <= 1'b0;
            state            <= ISSUE;
          end
        end
        // The write on the port now commits on the same edge the RAM samples our read,
        // so the read returns stale data; remember it for substitution in CAPTURE.
        ISSUE: begin
          fwd0     <= oRamWriteEnable && (oRamWriteAddress == oRamReadAddress0);
          fwd1     <= oRamWriteEnable && (oRamWriteAddress == oRamReadAddress1);
          fwd_data <= oRamWriteData;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          oOperand0      <= fwd0 ? fwd_data : iRamDataOut0;
          oOperand1      <= fwd1 ? fwd_data : iRamDataOut1;
          oOperandsValid <= 1'b1;
          state          <= VALID;
        end
        VALID: begin
          if (iAccept) begin
            oOperandsValid <= 1'b0;
            oReady         <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          oOperandsValid <= 1'b0;
          oReady         <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_operand_fetch.sv
// Randomized scoreboard bench for ram_operand_fetch: a behavioural RAM, a snapshot memory model and
// a monitor that checks latency, operand values and the accept handshake.
module tb_ram_operand_fetch;

  localparam int DW = 96;
  localparam int AW = 7;

  logic          Clock;
  logic          Reset;
  logic          iRequest;
  logic [AW-1:0] iSrcAddr0;
  logic [AW-1:0] iSrcAddr1;
  logic          oReady;
  logic          oOperandsValid;
  logic [DW-1:0] oOperand0;
  logic [DW-1:0] oOperand1;
  logic          iAccept;
  logic          iWbValid;
  logic [AW-1:0] iWbAddr;
  logic [DW-1:0] iWbData;
  logic          oRamWriteEnable;
  logic [AW-1:0] oRamWriteAddress;
  logic [DW-1:0] oRamWriteData;
  logic [AW-1:0] oRamReadAddress0;
  logic [AW-1:0] oRamReadAddress1;
  logic [DW-1:0] iRamDataOut0;
  logic [DW-1:0] iRamDataOut1;

  ram_operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .iRequest(iRequest), .iSrcAddr0(iSrcAddr0), .iSrcAddr1(iSrcAddr1),
    .oReady(oReady), .oOperandsValid(oOperandsValid),
    .oOperand0(oOperand0), .oOperand1(oOperand1), .iAccept(iAccept),
    .iWbValid(iWbValid), .iWbAddr(iWbAddr), .iWbData(iWbData),
    .oRamWriteEnable(oRamWriteEnable), .oRamWriteAddress(oRamWriteAddress),
    .oRamWriteData(oRamWriteData),
    .oRamReadAddress0(oRamReadAddress0), .oRamReadAddress1(oRamReadAddress1),
    .iRamDataOut0(iRamDataOut0), .iRamDataOut1(iRamDataOut1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Behavioural RAM: read returns the contents before a same-edge write.
  logic [DW-1:0] ram [128];
  always @(posedge Clock) begin
    iRamDataOut0 <= ram[oRamReadAddress0];
    iRamDataOut1 <= ram[oRamReadAddress1];
    if (oRamWriteEnable) ram[oRamWriteAddress] <= oRamWriteData;
  end

  // Reference: architectural memory as the execute stage sees it.
  logic [DW-1:0] ref_mem [128];

  typedef struct {
    logic [DW-1:0] o0;
    logic [DW-1:0] o1;
    int            vcyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the snapshot taken at an accepted request includes this cycle's write.
  task automatic cycle(input logic req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic wb, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic acc);
    exp_t e;
    iRequest  = req;
    iSrcAddr0 = a0;
    iSrcAddr1 = a1;
    iWbValid  = wb;
    iWbAddr   = wa;
    iWbData   = wd;
    iAccept   = acc;
    if (wb) ref_mem[wa] = wd;
    if (req && oReady) begin
      e.o0   = ref_mem[a0];
      e.o1   = ref_mem[a1];
      e.vcyc = cyc + 3;
      exp_q.push_back(e);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n, input logic acc);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, acc);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    cycle(1'b0, '0, '0, 1'b1, wa, wd, 1'b1);
  endtask

  // Monitor
  exp_t cur;
  logic have_cur = 1'b0;
  logic prev_v   = 1'b0;
  logic prev_acc = 1'b0;

  always @(negedge Clock) begin
    if (!Reset) begin
      have_cur = 1'b0;
      prev_v   = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) begin
        check("ready_after_accept", DW'(oReady), DW'(1));
        check("valid_clear_after_accept", DW'(oOperandsValid), DW'(0));
      end
      if (oOperandsValid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", DW'(1), DW'(0));
          have_cur = 1'b0;
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("valid_latency", DW'(cyc), DW'(cur.vcyc));
        end
      end
      if (oOperandsValid && have_cur) begin
        check("operand0", oOperand0, cur.o0);
        check("operand1", oOperand1, cur.o1);
      end
      prev_acc = oOperandsValid && iAccept;
      prev_v   = oOperandsValid;
    end
  end

  logic [DW-1:0] old7;
  logic          seen;

  initial begin
    Reset = 1'b0;
    iRequest = 1'b0; iSrcAddr0 = '0; iSrcAddr1 = '0; iAccept = 1'b0;
    iWbValid = 1'b0; iWbAddr = '0; iWbData = '0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    check("rst_ready", DW'(oReady), DW'(1));
    check("rst_valid", DW'(oOperandsValid), DW'(0));
    check("rst_wren", DW'(oRamWriteEnable), DW'(0));
    check("rst_waddr", DW'(oRamWriteAddress), DW'(0));
    check("rst_wdata", oRamWriteData, '0);
    check("rst_raddr0", DW'(oRamReadAddress0), DW'(0));
    check("rst_raddr1", DW'(oRamReadAddress1), DW'(0));
    check("rst_op0", oOperand0, '0);
    check("rst_op1", oOperand1, '0);
    @(posedge Clock);
    #1;

    for (int a = 0; a < 16; a++) wr(AW'(a), {$urandom, $urandom, $urandom});
    idle(2, 1'b1);

    // Basic fetch
    wr(7'd5, {12{8'hA5}});
    wr(7'd9, {12{8'hB9}});
    idle(2, 1'b1);
    cycle(1'b1, 7'd5, 7'd9, 1'b0, '0, '0, 1'b1);
    idle(5, 1'b1);

    // Forward of the write on the port during ISSUE
    wr(7'd5, DW'(96'h11));
    idle(2, 1'b1);
    cycle(1'b1, 7'd5, 7'd5, 1'b1, 7'd5, DW'(96'h22), 1'b1);
    idle(5, 1'b1);

    // Late write excluded, then visible to the next fetch
    wr(7'd5, DW'(96'h11));
    idle(2, 1'b1);
    cycle(1'b1, 7'd5, 7'd3, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 7'd5, DW'(96'h33), 1'b1);
    idle(4, 1'b1);
    cycle(1'b1, 7'd5, 7'd5, 1'b0, '0, '0, 1'b1);
    idle(5, 1'b1);

    // Backpressure with ignored requests
    cycle(1'b1, 7'd1, 7'd2, 1'b0, '0, '0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (oOperandsValid) seen = 1'b1;
      else idle(1, 1'b0);
    end
    check("bp_valid_seen", DW'(seen), DW'(1));
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", DW'(oReady), DW'(0));
      cycle(1'b1, 7'd1, 7'd2, 1'b0, '0, '0, 1'b0);
    end
    idle(6, 1'b1);

    // Reset during CAPTURE with a pending registered write
    old7 = ref_mem[7];
    cycle(1'b1, 7'd7, 7'd7, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 7'd7, ~old7, 1'b1);
    iWbValid = 1'b0;
    check("cap_ready_low", DW'(oReady), DW'(0));
    check("cap_write_pending", DW'(oRamWriteEnable), DW'(1));
    Reset = 1'b0;
    exp_q.delete();
    ref_mem[7] = old7;
    #2;
    check("arst_ready", DW'(oReady), DW'(1));
    check("arst_valid", DW'(oOperandsValid), DW'(0));
    check("arst_wren", DW'(oRamWriteEnable), DW'(0));
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("arst_ram_unchanged", ram[7], old7);
    cycle(1'b1, 7'd7, 7'd7, 1'b0, '0, '0, 1'b1);
    idle(5, 1'b1);

    // Randomized traffic on a small address range to provoke forwarding
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    idle(10, 1'b1);
    check("queue_drained", DW'(exp_q.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_operand_fetch.md
# ram_operand_fetch

Initiator-side controller for the dual-read-port data RAM. It accepts a two-operand read request and drives both RAM read addresses. It captures the one-cycle-latency read data and presents the operand pair to the execute stage under a valid/accept handshake. It also registers execute write-backs onto the RAM write port and forwards a same-address write that the RAM's read-before-write timing would otherwise miss.

## Interface
- DATA_WIDTH, 96: RAM row width in bits.
- ADDR_WIDTH, 7: RAM address width in bits.

- Clock  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iRequest  input  1  operand fetch request.
- iSrcAddr0  input  ADDR_WIDTH  source address 0.
- iSrcAddr1  input  ADDR_WIDTH  source address 1.
- oReady  output  1  high when a request can be accepted (state IDLE).
- oOperandsValid  output  1  operand pair valid.
- oOperand0  output  DATA_WIDTH  data at iSrcAddr0.
- oOperand1  output  DATA_WIDTH  data at iSrcAddr1.
- iAccept  input  1  consumer takes the operand pair.
- iWbValid  input  1  write-back request; always accepted, no backpressure.
- iWbAddr  input  ADDR_WIDTH  write-back address.
- iWbData  input  DATA_WIDTH  write-back data.
- oRamWriteEnable  output  1  RAM write enable.
- oRamWriteAddress  output  ADDR_WIDTH  RAM write address.
- oRamWriteData  output  DATA_WIDTH  RAM write data.
- oRamReadAddress0  output  ADDR_WIDTH  RAM read port 0 address.
- oRamReadAddress1  output  ADDR_WIDTH  RAM read port 1 address.
- iRamDataOut0  input  DATA_WIDTH  RAM read data 0; valid one cycle after its address is sampled.
- iRamDataOut1  input  DATA_WIDTH  RAM read data 1; valid one cycle after its address is sampled.

## Operation
- RAM contract:
  - Reads and writes are sampled on the same edge.
  - A read at edge E returns the contents before the write committed at E.
- States: IDLE, ISSUE, CAPTURE, VALID.
- IDLE:
  - oReady=1.
  - On iRequest, latch iSrcAddr0/1 into oRamReadAddress0/1 and go to ISSUE.
- ISSUE:
  - The RAM samples the read addresses at the end of this cycle.
  - Per port k, set fwd_k = oRamWriteEnable && (oRamWriteAddress == oRamReadAddressk).
  - Store oRamWriteData in fwd_data.
  - Go to CAPTURE.
- CAPTURE:
  - oOperandk <= fwd_k ? fwd_data : iRamDataOutk.
  - Go to VALID.
- VALID:
  - oOperandsValid=1; operands held stable.
  - On iAccept, go to IDLE and clear oOperandsValid.
- iRequest is ignored in every state other than IDLE.
- Write path, one-stage register every cycle:
  - oRamWriteEnable <= iWbValid.
  - Address and data are loaded only when iWbValid=1.
- Snapshot rule: the operands reflect every write-back with iWbValid sampled at or before the accept cycle, and none sampled after it.
- Duplicate addresses (iSrcAddr0 == iSrcAddr1) are legal. Both operands are identical, and both are forwarded when a forward condition applies.

## Timing
- Request accepted at cycle T:
  - ISSUE at T+1.
  - CAPTURE at T+2.
  - oOperandsValid=1 from T+3.
- Minimum request-to-valid latency is 3 cycles.
- iAccept at cycle V: oOperandsValid=0 and oReady=1 at V+1. The earliest next accept is at V+1.
- Peak throughput is one fetch per 4 cycles.
- Write-back latency: iWbValid at cycle W puts the write on the RAM port at W+1. The write commits at the end of W+1.
- Forwarding window:
  - Only a write on the RAM port during ISSUE (iWbValid at T) is forwarded.
  - Writes with iWbValid at T-1 or earlier are already in RAM when read.
  - Writes with iWbValid at T+1 or later are excluded from the snapshot.
- Reset (asserted low, asynchronous):
  - State goes to IDLE; oReady=1.
  - oOperandsValid, oOperand0/1, oRamWrite*, oRamReadAddress0/1, fwd_k and fwd_data go to 0.
- Reset mid-operation: an in-flight fetch is abandoned, and a registered write not yet committed is dropped.
- After deassertion, the first request is accepted on the next edge on which iRequest=1.

## Test plan
- Reset check:
  - Stimulus: assert Reset low, deassert it, hold iRequest=0 and iWbValid=0.
  - Response: oReady=1, oOperandsValid=0, oRamWriteEnable=0, and all data and address outputs are 0.
- Basic fetch:
  - Stimulus: write addr 5=0x...A5 and addr 9=0x...B9, then 2 idle cycles, then a request for (5,9) at T.
  - Response: oOperandsValid rises at T+3 with oOperand0=0x...A5 and oOperand1=0x...B9.
- Forward:
  - Stimulus: addr 5 holds 0x11; at T, iWbValid with addr 5=0x22 together with a request for (5,5).
  - Response: both operands are 0x22.
- Excluded late write:
  - Stimulus: addr 5 holds 0x11; request (5,3) at T; write addr 5=0x33 at T+1.
  - Response: oOperand0=0x11. A following fetch of (5,5) returns 0x33.
- Backpressure:
  - Stimulus: hold iAccept=0 for 5 cycles in VALID while pulsing iRequest with (1,2).
  - Response: operands are stable, oReady=0, and the request is ignored. After iAccept, oReady=1 on the next cycle.
- Reset during CAPTURE:
  - Stimulus: pull Reset low during CAPTURE while a registered write is pending.
  - Response: state IDLE, oOperandsValid=0, oRamWriteEnable=0, and the RAM location is unchanged.
